// File: rtl/fc_stream_loader.sv
// fc_stream_loader
// Front end for a combinational fully-connected layer. Serial WIDTH-bit
// activations arrive over valid/ready and are assembled into the registered
// IN-entry vector x. One cycle after the vector is complete, the layer result
// z_in is captured and presented on a valid/ready output.
//
// Optional feature macro: FC_LOADER_REQUANT_EN
//   When defined, the captured result is requantised to an activation:
//   min(z_in >> SHIFT, 2^WIDTH-1), zero-extended to OUT_W.
//   When undefined, z_in is captured unchanged.
module fc_stream_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 128,
  parameter int OUT_W = WIDTH*2+$clog2(IN),
  parameter int SHIFT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [OUT_W-1:0] z_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             err_len
);

  localparam int            CW      = $clog2(IN);
  localparam logic [CW-1:0] CNT_MAX = CW'(IN - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] x_r [0:IN-1];
  logic             m_valid_r;
  logic [OUT_W-1:0] m_data_r;
  logic             err_len_r;

  logic             accept_s;
  logic             cnt_at_max_s;
  logic             frame_end_s;
  logic             len_bad_s;
  logic             release_s;
  logic [OUT_W-1:0] result_s;

`ifdef FC_LOADER_REQUANT_EN
  // Shift down and saturate to the largest WIDTH-bit activation; upper bits stay zero.
  function automatic logic [OUT_W-1:0] requant(input logic [OUT_W-1:0] z);
    logic [OUT_W-1:0] shifted;
    logic [OUT_W-1:0] sat_max;
    sat_max = OUT_W'({WIDTH{1'b1}});
    shifted = z >> SHIFT;
    if (shifted > sat_max) begin
      requant = sat_max;
    end else begin
      requant = shifted;
    end
  endfunction

  assign result_s = requant(z_in);
`else
  assign result_s = z_in;
`endif

  // Ready is a decode of the registered state, forced low while reset is held.
  assign s_ready      = (state_r == ST_FILL) && !rst;
  assign accept_s     = s_valid && s_ready;
  assign cnt_at_max_s = (cnt_r == CNT_MAX);
  // A frame closes on s_last or on the IN-th sample, whichever comes first.
  assign frame_end_s  = accept_s && (s_last || cnt_at_max_s);
  // Length is wrong when s_last and the IN-th position disagree.
  assign len_bad_s    = s_last ^ cnt_at_max_s;
  assign release_s    = (state_r == ST_HOLD) && m_valid_r && m_ready;

  assign x       = x_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign err_len = err_len_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: FILL until frame end, one SETTLE cycle, HOLD until the result is taken.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (frame_end_s) begin
          state_next_s = ST_SETTLE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_SETTLE: begin
        state_next_s = ST_HOLD;
      end
      ST_HOLD: begin
        if (release_s) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_FILL;
      end
    endcase
  end

  // Write index: advances per accepted sample and rewinds at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_ZERO;
    end else if (frame_end_s) begin
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Activation vector: cleared after reset or result release so short frames are zero-padded.
  always_ff @(posedge clk) begin
    if (rst || release_s) begin
      for (int i = 0; i < IN; i++) begin
        x_r[i] <= {WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      x_r[cnt_r] <= s_data;
    end else begin
      x_r <= x_r;
    end
  end

  // Result capture at the end of SETTLE; valid drops on the output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_data_r  <= {OUT_W{1'b0}};
    end else if (state_r == ST_SETTLE) begin
      m_valid_r <= 1'b1;
      m_data_r  <= result_s;
    end else if (release_s) begin
      m_valid_r <= 1'b0;
      m_data_r  <= m_data_r;
    end else begin
      m_valid_r <= m_valid_r;
      m_data_r  <= m_data_r;
    end
  end

  // Length-error flag: raised at the closing edge of a bad frame, so it is high only in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_len_r <= 1'b0;
    end else begin
      err_len_r <= frame_end_s && len_bad_s;
    end
  end

endmodule

// File: tb/tb_fc_stream_loader.sv
// Testbench for fc_stream_loader. A layer stub drives z_in = 3 * sum(x).
// Build with FC_LOADER_REQUANT_EN defined to exercise the requantised output (SHIFT=2).
module tb_fc_stream_loader;

  localparam int WIDTH = 8;
  localparam int IN    = 128;
  localparam int OUT_W = 23;
`ifdef FC_LOADER_REQUANT_EN
  localparam int SHIFT = 2;
`else
  localparam int SHIFT = 7;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic [WIDTH-1:0] x [0:IN-1];
  logic [OUT_W-1:0] z_in;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_data;
  logic             err_len;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // m_ready source: 0 = always high, 1 = random, 2 = forced by the test sequence
  int   mr_mode  = 0;
  logic mr_force = 1'b0;
  logic mr_rand  = 1'b1;
  assign m_ready = (mr_mode == 2) ? mr_force : ((mr_mode == 1) ? mr_rand : 1'b1);

  // Layer stub, with an override for driving z_in directly
  logic             use_zovr = 1'b0;
  logic [OUT_W-1:0] zovr     = 23'd0;
  int unsigned      stub_acc;
  always_comb begin
    stub_acc = 32'd0;
    for (int i = 0; i < IN; i++) stub_acc = stub_acc + 32'(x[i]);
    z_in = use_zovr ? zovr : OUT_W'(stub_acc * 32'd3);
  end

  fc_stream_loader #(.WIDTH(WIDTH), .IN(IN), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .x(x), .z_in(z_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .err_len(err_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mr_rand = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: results taken on handshake, err_len pulses, m_valid rise time
  logic [OUT_W-1:0] res_q[$];
  int   err_cnt   = 0;
  int   err_cyc   = -1;
  int   rise_cyc  = -1;
  logic mv_prev   = 1'b0;
  always @(negedge clk) begin
    if (err_len) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (m_valid && !mv_prev) rise_cyc <= cyc;
    mv_prev <= m_valid;
    if (m_valid && m_ready && !rst) res_q.push_back(m_data);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference result: layer value passed through the loader's output function
  function automatic logic [OUT_W-1:0] model_f(input longint z);
`ifdef FC_LOADER_REQUANT_EN
    longint q;
    longint lim;
    lim = (longint'(1) << WIDTH) - 1;
    q   = z / (longint'(1) << SHIFT);
    if (q > lim) q = lim;
    return OUT_W'(q);
`else
    return OUT_W'(z);
`endif
  endfunction

  function automatic bit x_all_zero();
    for (int i = 0; i < IN; i++) if (x[i] !== 8'd0) return 1'b0;
    return 1'b1;
  endfunction

  logic [WIDTH-1:0] fv [0:IN-1];
  int gap_pct = 0;

  task automatic send_sample(input logic [WIDTH-1:0] d, input logic last, output int acc_edge);
    int guard;
    guard = 0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready stayed 0 for %0d cycles, expected 1", guard);
    end
    @(posedge clk);
    #1;
    acc_edge = cyc;
    s_valid  = 1'b0;
    s_last   = 1'b0;
  endtask

  task automatic wait_result(input string name, input int base, output logic [OUT_W-1:0] got, output bit ok);
    int guard;
    guard = 0;
    while (res_q.size() <= base && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    ok  = (res_q.size() > base);
    got = ok ? res_q[base] : 23'd0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_result_timeout: got no result, expected one within 300 cycles", name);
    end
  endtask

  // Send fv[0..len-1] as one frame and check vector, result, latency and error flag
  task automatic run_frame(input string name, input int len, input bit with_last,
                           input logic [OUT_W-1:0] exp_m, input bit exp_err);
    int               base_res;
    int               base_err;
    int               acc_edge;
    bit               x_ok;
    bit               ok;
    logic [OUT_W-1:0] got;
    base_res = res_q.size();
    base_err = err_cnt;
    acc_edge = 0;
    for (int i = 0; i < len; i++) send_sample(fv[i], with_last && (i == len - 1), acc_edge);
    check({name, "_sready_settle"}, 64'(s_ready), 64'd0);
    x_ok = 1'b1;
    for (int j = 0; j < IN; j++) begin
      if (x[j] !== ((j < len) ? fv[j] : 8'd0)) x_ok = 1'b0;
    end
    check({name, "_x_vector"}, 64'(x_ok), 64'd1);
    wait_result(name, base_res, got, ok);
    if (ok) begin
      check({name, "_m_data"}, 64'(got), 64'(exp_m));
      // accept at edge E, SETTLE follows, result registered at edge E+1
      check({name, "_latency"}, 64'(rise_cyc - acc_edge), 64'd1);
    end
    check({name, "_err_pulses"}, 64'(err_cnt - base_err), 64'(exp_err));
    if (exp_err) check({name, "_err_in_settle"}, 64'(err_cyc), 64'(acc_edge));
  endtask

  typedef struct {
    int          len;
    logic [7:0]  val;
    bit          with_last;
    longint      exp_z;
    bit          exp_err;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int               acc;
    int               base_err;
    int               base_res;
    longint           sum;
    int               len;
    bit               wl;
    bit               ok;
    bit               x_ok;
    logic [OUT_W-1:0] got;
    logic [OUT_W-1:0] md;
    logic [WIDTH-1:0] xs [0:IN-1];

    tbl[0] = '{128, 8'd1,   1'b1, 64'd384,   1'b0};
    tbl[1] = '{10,  8'd5,   1'b1, 64'd150,   1'b1};
    tbl[2] = '{128, 8'd255, 1'b1, 64'd97920, 1'b0};
    tbl[3] = '{1,   8'd7,   1'b1, 64'd21,    1'b1};
    tbl[4] = '{127, 8'd4,   1'b1, 64'd1524,  1'b1};
    tbl[5] = '{128, 8'd3,   1'b0, 64'd1152,  1'b1};
    tbl[6] = '{128, 8'd0,   1'b1, 64'd0,     1'b0};

    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'd0;
    s_last  = 1'b0;
    acc     = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", 64'(s_ready), 64'd0);
    check("reset_m_valid", 64'(m_valid), 64'd0);
    check("reset_m_data", 64'(m_data), 64'd0);
    check("reset_err_len", 64'(err_len), 64'd0);
    check("reset_x_zero", 64'(x_all_zero()), 64'd1);
    rst = 1'b0;
    #1;
    check("release_s_ready", 64'(s_ready), 64'd1);

    // Table-driven constant-value frames
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < IN; i++) fv[i] = tbl[t].val;
      run_frame($sformatf("tbl%0d", t), tbl[t].len, tbl[t].with_last,
                model_f(tbl[t].exp_z), tbl[t].exp_err);
    end

    // Missing s_last over 130 samples: samples 129-130 start the next frame
    for (int i = 0; i < IN; i++) fv[i] = 8'd2;
    run_frame("miss", IN, 1'b0, model_f(64'd768), 1'b1);
    send_sample(8'd2, 1'b0, acc);
    send_sample(8'd2, 1'b0, acc);
    check("miss_next_x0", 64'(x[0]), 64'd2);
    check("miss_next_x1", 64'(x[1]), 64'd2);
    check("miss_next_x2", 64'(x[2]), 64'd0);
    base_res = res_q.size();
    base_err = err_cnt;
    send_sample(8'd0, 1'b1, acc);
    wait_result("miss_next", base_res, got, ok);
    if (ok) check("miss_next_m_data", 64'(got), 64'(model_f(64'd12)));
    check("miss_next_err_pulses", 64'(err_cnt - base_err), 64'd1);

    // Backpressure: m_ready low for 5 cycles after m_valid, stray s_valid ignored
    mr_mode  = 2;
    mr_force = 1'b0;
    sum      = 0;
    for (int i = 0; i < 5; i++) begin
      fv[i] = 8'($urandom_range(0, 255));
      sum   = sum + longint'(fv[i]);
    end
    base_res = res_q.size();
    for (int i = 0; i < 5; i++) send_sample(fv[i], i == 4, acc);
    for (int g = 0; g < 20 && !m_valid; g++) begin
      @(posedge clk);
      #1;
    end
    check("bp_m_valid", 64'(m_valid), 64'd1);
    check("bp_m_data", 64'(m_data), 64'(model_f(3 * sum)));
    md = m_data;
    for (int i = 0; i < IN; i++) xs[i] = x[i];
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom_range(0, 255));
      s_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      x_ok = 1'b1;
      for (int i = 0; i < IN; i++) if (x[i] !== xs[i]) x_ok = 1'b0;
      check($sformatf("bp_hold%0d_s_ready", k), 64'(s_ready), 64'd0);
      check($sformatf("bp_hold%0d_m_data", k), 64'(m_data), 64'(md));
      check($sformatf("bp_hold%0d_x", k), 64'(x_ok), 64'd1);
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    mr_force = 1'b1;
    @(posedge clk);
    #1;
    mr_force = 1'b0;
    check("bp_after_s_ready", 64'(s_ready), 64'd1);
    check("bp_after_m_valid", 64'(m_valid), 64'd0);
    check("bp_after_x_zero", 64'(x_all_zero()), 64'd1);
    check("bp_taken_count", 64'(res_q.size() - base_res), 64'd1);
    mr_mode = 0;

    // Reset after 50 accepts drops the partial frame without an error pulse
    for (int i = 0; i < 50; i++) send_sample(8'($urandom_range(1, 255)), 1'b0, acc);
    base_err = err_cnt;
    rst = 1'b1;
    #1;
    check("midrst_s_ready_low", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_m_valid", 64'(m_valid), 64'd0);
    check("midrst_x_zero", 64'(x_all_zero()), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_err", 64'(err_cnt - base_err), 64'd0);
    sum = 0;
    for (int i = 0; i < IN; i++) begin
      fv[i] = 8'($urandom_range(0, 255));
      sum   = sum + longint'(fv[i]);
    end
    run_frame("midrst_full", IN, 1'b1, model_f(3 * sum), 1'b0);

`ifdef FC_LOADER_REQUANT_EN
    // Requantisation: shift by 2 then saturate to 255
    use_zovr = 1'b1;
    fv[0]    = 8'd1;
    zovr     = 23'd1000;
    run_frame("rq_1000", 1, 1'b1, 23'd250, 1'b1);
    check("rq_1000_upper", 64'(m_data[22:8]), 64'd0);
    zovr     = 23'd5000;
    run_frame("rq_5000", 1, 1'b1, 23'd255, 1'b1);
    check("rq_5000_upper", 64'(m_data[22:8]), 64'd0);
    use_zovr = 1'b0;
`endif

    // Randomised frames against the reference model, with input gaps and random m_ready
    mr_mode = 1;
    gap_pct = 20;
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, IN);
      wl  = (len < IN) ? 1'b1 : 1'($urandom_range(0, 1));
      sum = 0;
      for (int i = 0; i < len; i++) begin
        fv[i] = 8'($urandom_range(0, 255));
        sum   = sum + longint'(fv[i]);
      end
      run_frame($sformatf("rnd%0d", f), len, wl, model_f(3 * sum), (len < IN) || !wl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_stream_loader.md
# fc_stream_loader

Sequential front end for the combinational fully-connected neuron layers. It accepts a serial stream of WIDTH-bit activations through a valid/ready handshake and assembles them into the registered IN-entry parallel vector that drives the layer's x bus. After the layer's adder tree has settled, it captures the layer's post-ReLU result z and returns it on a valid/ready output. It sits between the upstream activation stream and one layer instance.

## Interface
- WIDTH, 8: activation width in bits.
- IN, 128: number of layer inputs, which is the frame length.
- OUT_W, WIDTH*2+$clog2(IN) (23): width of the layer result z_in and of m_data.
- SHIFT, 7: right shift applied before saturation. Used only when FC_LOADER_REQUANT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  loader can accept a sample.
- s_data  in  WIDTH  activation sample.
- s_last  in  1  marks the final sample of a frame.
- x  out  [WIDTH-1:0] x[0:IN-1]  registered vector; connects to the layer's x input.
- z_in  in  OUT_W  combinational result from the layer's z output.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  OUT_W  captured result.
- err_len  out  1  one-cycle pulse when a frame's length does not match IN.

## Operation
- A sample is accepted on any cycle where s_valid && s_ready.
- Index counter cnt runs 0..IN-1, is $clog2(IN) bits wide, and resets to 0.
- FSM states: FILL, SETTLE, HOLD. Reset state is FILL.
  - FILL: s_ready=1. An accepted sample writes x[cnt] <= s_data and increments cnt. The frame ends when the accepted sample has s_last=1 or cnt==IN-1. Frame end sets cnt to 0 and moves to SETTLE.
  - SETTLE: lasts exactly one cycle; s_ready=0. At the closing edge: m_data <= f(z_in), m_valid <= 1, go to HOLD.
  - HOLD: s_ready=0. On m_valid && m_ready: m_valid <= 0, clear every x[i] to 0, go to FILL.
- Unwritten entries are zero. After reset or a HOLD->FILL transition all x entries are 0, so an early s_last leaves the remaining entries at zero.
- Length errors: err_len pulses for one cycle in SETTLE when either
  - s_last arrives with cnt<IN-1 (short frame), or
  - the IN-th sample arrives without s_last. The frame still ends, and the next accepted sample starts a new frame at x[0].
- x and m_data stay stable in HOLD regardless of s_valid activity.
- The loader applies no arithmetic to activations. The layer's z is already ReLU-clipped and non-negative.

## Timing
- Reset values: s_ready=0 while rst=1, then 1 from the first cycle after release. m_valid=0, m_data=0, err_len=0, all x=0, cnt=0.
- Last accepted sample at cycle t:
  - x is complete after edge t, so the layer evaluates during cycle t+1 (SETTLE).
  - m_valid=1 from cycle t+2.
- s_ready returns to 1 on the cycle after the m_valid && m_ready handshake.
- Minimum frame period is IN+2 cycles when m_ready is held high.
- rst asserted mid-frame or in HOLD: the partial frame or pending result is dropped, all state returns to reset values at that edge, and no err_len pulse is generated.
- s_valid held low in FILL: cnt and x hold, with no timeout.
- m_ready asserted while m_valid=0 has no effect.

## Configuration
- FC_LOADER_REQUANT_EN defined:
  - f(z) = min(z_in >> SHIFT, 2^WIDTH-1).
  - The value is zero-extended to OUT_W, so m_data[OUT_W-1:WIDTH] is always 0. This gives an activation ready for the next layer.
- Not defined: f(z) = z_in unchanged at full OUT_W width.

## Test plan
- Full frame: IN samples of value 1, s_last on sample 127, m_ready=1, layer stub with z_in = sum(x)·3 -> m_data=384, m_valid rises exactly 2 cycles after the last accept, err_len stays 0.
- Short frame: 10 samples of value 5 with s_last on the 10th -> x[0..9]=5, x[10..127]=0, m_data=150 (stub), err_len pulses once in SETTLE.
- Missing last: 130 samples of value 2, s_last never set -> first result 768, err_len pulses once, samples 129-130 land in x[0..1] of the next frame.
- Backpressure: m_ready low for 5 cycles after m_valid -> s_ready stays 0, and m_data and x stay stable; handshake on cycle 6, s_ready=1 on the following cycle, all x read 0.
- Reset mid-frame: rst for 1 cycle after 50 accepts -> cnt=0, all x=0, m_valid=0; the next full frame produces the correct result.
- FC_LOADER_REQUANT_EN with SHIFT=2:
  - z_in=1000 -> m_data=250.
  - z_in=5000 -> m_data=255 (saturated).
  - m_data[22:8]=0 in both cases.
